// File: rtl/axilm_pkg.sv
// rtl/axilm_pkg.sv - shared types and constants for the AXI-Lite master bus arbiter
package axilm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Increment modulo n without needing n to be a power of two.
  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/axilm_bus_arb_if.sv
// rtl/axilm_bus_arb_if.sv - local interface between the arbiter and the AXI-Lite master
interface axilm_bus_arb_if;

  logic        BUS_ENA;
  logic [3:0]  BUS_WSTB;
  logic [31:0] BUS_ADDR;
  logic [31:0] BUS_WDATA;
  logic        BUS_DONE;
  logic [31:0] BUS_RDATA;
  logic [1:0]  BUS_RESP;

  modport master (
    output BUS_ENA, BUS_WSTB, BUS_ADDR, BUS_WDATA,
    input  BUS_DONE, BUS_RDATA, BUS_RESP
  );

  modport slave (
    input  BUS_ENA, BUS_WSTB, BUS_ADDR, BUS_WDATA,
    output BUS_DONE, BUS_RDATA, BUS_RESP
  );

endinterface

// File: rtl/axilm_rr_pick.sv
// rtl/axilm_rr_pick.sv - combinational round-robin picker, first set bit at or after ptr
module axilm_rr_pick #(
  parameter int NREQ  = 2,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic             hit,
  output logic [IDX_W-1:0] idx
);

  // Scan offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin : pick
    logic [IDX_W-1:0] slot;
    hit  = 1'b0;
    idx  = '0;
    slot = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      slot = IDX_W'((int'(ptr) + k) % NREQ);
      if (req[slot]) begin
        hit = 1'b1;
        idx = slot;
      end
    end
  end

endmodule

// File: rtl/axilm_bus_arb.sv
// rtl/axilm_bus_arb.sv - round-robin arbiter with watchdog in front of the AXI-Lite master
module axilm_bus_arb
  import axilm_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 16
) (
  input  logic                 ACLK,
  input  logic                 ARESETn,
  input  logic [NREQ-1:0]      REQ_ENA,
  input  logic [4*NREQ-1:0]    REQ_WSTB,
  input  logic [32*NREQ-1:0]   REQ_ADDR,
  input  logic [32*NREQ-1:0]   REQ_WDATA,
  output logic [NREQ-1:0]      REQ_ACK,
  output logic [31:0]          REQ_RDATA,
  output logic [1:0]           REQ_RESP,
  axilm_bus_arb_if.master      bus
);

  localparam int               IDX_W   = $clog2(NREQ);
  localparam bit               WD_EN   = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] rr_q, rr_d;
  logic [CNT_W-1:0] wdog_q, wdog_d;
  logic [NREQ-1:0]  ack_d;
  logic [31:0]      rdata_d;
  logic [1:0]       resp_d;
  logic             ena_q, ena_d;
  logic [3:0]       wstb_q, wstb_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             pick_hit;
  logic [IDX_W-1:0] pick_idx;

  axilm_rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req (REQ_ENA),
    .ptr (rr_q),
    .hit (pick_hit),
    .idx (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    wdog_d  = wdog_q;
    ack_d   = '0;
    rdata_d = REQ_RDATA;
    resp_d  = REQ_RESP;
    ena_d   = 1'b0;
    wstb_d  = wstb_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (pick_hit) begin
          grant_d = pick_idx;
          ena_d   = 1'b1;
          wstb_d  = REQ_WSTB[4*pick_idx +: 4];
          addr_d  = REQ_ADDR[32*pick_idx +: 32];
          wdata_d = REQ_WDATA[32*pick_idx +: 32];
          wdog_d  = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // A completion arriving on the expiry cycle still counts as a normal one.
        if (bus.BUS_DONE) begin
          ack_d   = NREQ'(1) << grant_q;
          rdata_d = bus.BUS_RDATA;
          resp_d  = bus.BUS_RESP;
          rr_d    = IDX_W'(wrap_inc(int'(grant_q), NREQ));
          state_d = IDLE;
        end else if (WD_EN && wdog_q == WD_LAST) begin
          ack_d   = NREQ'(1) << grant_q;
          rdata_d = '0;
          resp_d  = RESP_DECERR;
          rr_d    = IDX_W'(wrap_inc(int'(grant_q), NREQ));
          state_d = DRAIN;
        end else begin
          wdog_d = wdog_q + CNT_W'(1);
        end
      end
      DRAIN: begin
        if (bus.BUS_DONE) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      rr_q      <= '0;
      wdog_q    <= '0;
      REQ_ACK   <= '0;
      REQ_RDATA <= '0;
      REQ_RESP  <= '0;
      ena_q     <= 1'b0;
      wstb_q    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_q      <= rr_d;
      wdog_q    <= wdog_d;
      REQ_ACK   <= ack_d;
      REQ_RDATA <= rdata_d;
      REQ_RESP  <= resp_d;
      ena_q     <= ena_d;
      wstb_q    <= wstb_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign bus.BUS_ENA   = ena_q;
  assign bus.BUS_WSTB  = wstb_q;
  assign bus.BUS_ADDR  = addr_q;
  assign bus.BUS_WDATA = wdata_q;

endmodule

// File: tb/tb_axilm_bus_arb.sv
// tb/tb_axilm_bus_arb.sv - self-checking bench for axilm_bus_arb
module tb_axilm_bus_arb;
  import axilm_pkg::*;

  localparam int NREQ    = 2;
  localparam int TIMEOUT = 8;
  localparam int CNT_W   = 16;

  logic         ACLK = 1'b0;
  logic         ARESETn = 1'b0;
  logic [1:0]   REQ_ENA = '0;
  logic [7:0]   REQ_WSTB = '0;
  logic [63:0]  REQ_ADDR = '0;
  logic [63:0]  REQ_WDATA = '0;
  logic [1:0]   REQ_ACK;
  logic [31:0]  REQ_RDATA;
  logic [1:0]   REQ_RESP;

  axilm_bus_arb_if bus ();

  axilm_bus_arb #(
    .NREQ    (NREQ),
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .ACLK      (ACLK),
    .ARESETn   (ARESETn),
    .REQ_ENA   (REQ_ENA),
    .REQ_WSTB  (REQ_WSTB),
    .REQ_ADDR  (REQ_ADDR),
    .REQ_WDATA (REQ_WDATA),
    .REQ_ACK   (REQ_ACK),
    .REQ_RDATA (REQ_RDATA),
    .REQ_RESP  (REQ_RESP),
    .bus       (bus)
  );

  always #5 ACLK = ~ACLK;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0]  ack;
    logic [31:0] rdata;
    logic [1:0]  resp;
  } ack_t;

  typedef struct {
    logic [1:0]  ena;
    logic [3:0]  wstb0;
    logic [31:0] addr0;
    logic [31:0] wdata0;
    logic [3:0]  wstb1;
    logic [31:0] addr1;
    logic [31:0] wdata1;
    int          lat;
    logic [31:0] rdata;
    logic [1:0]  resp;
    int          g;
  } vec_t;

  ack_t exp_q[$];
  bit   outstanding = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] ena,
                              input logic [3:0] wstb0, input logic [31:0] addr0, input logic [31:0] wdata0,
                              input logic [3:0] wstb1, input logic [31:0] addr1, input logic [31:0] wdata1,
                              input int lat, input logic [31:0] rdata, input logic [1:0] resp, input int g);
    vec_t v;
    v.ena = ena; v.wstb0 = wstb0; v.addr0 = addr0; v.wdata0 = wdata0;
    v.wstb1 = wstb1; v.addr1 = addr1; v.wdata1 = wdata1;
    v.lat = lat; v.rdata = rdata; v.resp = resp; v.g = g;
    return v;
  endfunction

  // Scoreboard side: every ACK must match the oldest expectation; no issue while one is in flight.
  always @(negedge ACLK) begin
    ack_t e;
    if (ARESETn) begin
      if (bus.BUS_ENA) begin
        chk("ena_while_busy", 64'(outstanding), 64'd0);
        outstanding = 1'b1;
      end
      if (REQ_ACK != 2'b00) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack: got %0h expected none at %0t", REQ_ACK, $time);
        end else begin
          e = exp_q.pop_front();
          chk("sb_ack", 64'(REQ_ACK), 64'(e.ack));
          chk("sb_rdata", 64'(REQ_RDATA), 64'(e.rdata));
          chk("sb_resp", 64'(REQ_RESP), 64'(e.resp));
        end
      end
    end
  end

  task automatic done_drive(input logic [31:0] rdata, input logic [1:0] resp);
    bus.BUS_DONE  = 1'b1;
    bus.BUS_RDATA = rdata;
    bus.BUS_RESP  = resp;
    outstanding   = 1'b0;
  endtask

  task automatic done_clear();
    bus.BUS_DONE  = 1'b0;
    bus.BUS_RDATA = 32'hFFFF_FFFF;
    bus.BUS_RESP  = RESP_DECERR;
  endtask

  // Entered and left on a negedge with the arbiter idle.
  task automatic xfer(input vec_t v);
    logic [31:0] ea, ed;
    logic [3:0]  ew;
    logic [1:0]  eack;
    ack_t        e;
    ea   = (v.g == 1) ? v.addr1  : v.addr0;
    ed   = (v.g == 1) ? v.wdata1 : v.wdata0;
    ew   = (v.g == 1) ? v.wstb1  : v.wstb0;
    eack = 2'b01 << v.g;
    REQ_ENA   = v.ena;
    REQ_WSTB  = {v.wstb1, v.wstb0};
    REQ_ADDR  = {v.addr1, v.addr0};
    REQ_WDATA = {v.wdata1, v.wdata0};
    @(negedge ACLK);
    chk("issue_ena", 64'(bus.BUS_ENA), 64'd1);
    chk("issue_addr", 64'(bus.BUS_ADDR), 64'(ea));
    chk("issue_wstb", 64'(bus.BUS_WSTB), 64'(ew));
    chk("issue_wdata", 64'(bus.BUS_WDATA), 64'(ed));
    REQ_ENA   = '0;
    REQ_WSTB  = ~REQ_WSTB;
    REQ_ADDR  = ~REQ_ADDR;
    REQ_WDATA = ~REQ_WDATA;
    e.ack = eack; e.rdata = v.rdata; e.resp = v.resp;
    exp_q.push_back(e);
    repeat (v.lat) @(negedge ACLK);
    done_drive(v.rdata, v.resp);
    @(negedge ACLK);
    done_clear();
    chk("ack_timing", 64'(REQ_ACK), 64'(eack));
    chk("addr_held", 64'(bus.BUS_ADDR), 64'(ea));
    chk("wdata_held", 64'(bus.BUS_WDATA), 64'(ed));
    @(negedge ACLK);
    chk("ack_single", 64'(REQ_ACK), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  vec_t tbl[7];

  initial begin
    ack_t       e;
    int         ena_seen;
    int         order[4];
    logic [1:0] oh;

    tbl[0] = mk(2'b01, 4'h0, 32'h0000_1000, 32'h0,          4'h0, 32'h0000_1100, 32'h0,          3, 32'hDEAD_BEEF, RESP_OKAY,   0);
    tbl[1] = mk(2'b10, 4'h0, 32'h0000_1004, 32'h0,          4'hF, 32'h0000_2004, 32'h1234_5678,  2, 32'h0,         RESP_OKAY,   1);
    tbl[2] = mk(2'b11, 4'h1, 32'h0000_2100, 32'hAAAA_0001,  4'h0, 32'h0000_2200, 32'h0,          1, 32'hA5A5_0001, RESP_SLVERR, 0);
    tbl[3] = mk(2'b11, 4'h0, 32'h0000_2300, 32'h0,          4'hC, 32'h0000_2400, 32'hC0DE_0000,  4, 32'h0BAD_F00D, RESP_OKAY,   1);
    tbl[4] = mk(2'b10, 4'h0, 32'h0000_2500, 32'h0,          4'h0, 32'h0000_2600, 32'h0,          6, 32'h1357_9BDF, RESP_SLVERR, 1);
    tbl[5] = mk(2'b01, 4'h3, 32'h0000_2700, 32'h0000_BEEF,  4'h0, 32'h0000_2800, 32'h0,          1, 32'h0,         RESP_OKAY,   0);
    tbl[6] = mk(2'b11, 4'h0, 32'h0000_2900, 32'h0,          4'h0, 32'h0000_2A00, 32'h0,          2, 32'h2468_ACE0, RESP_OKAY,   1);
    order = '{0, 1, 0, 1};

    done_clear();
    bus.BUS_RESP = RESP_OKAY;

    // Reset state
    @(negedge ACLK);
    chk("rst_ack", 64'(REQ_ACK), 64'd0);
    chk("rst_rdata", 64'(REQ_RDATA), 64'd0);
    chk("rst_resp", 64'(REQ_RESP), 64'd0);
    chk("rst_ena", 64'(bus.BUS_ENA), 64'd0);
    chk("rst_addr", 64'(bus.BUS_ADDR), 64'd0);
    @(negedge ACLK);
    ARESETn = 1'b1;

    for (int i = 0; i < 7; i++) xfer(tbl[i]);

    // Watchdog expiry, then drain of the late completion while requester 1 waits.
    REQ_ENA   = 2'b01;
    REQ_ADDR  = {32'h3000_0000, 32'h0000_3000};
    REQ_WSTB  = '0;
    REQ_WDATA = '0;
    @(negedge ACLK);
    chk("to_issue", 64'(bus.BUS_ENA), 64'd1);
    chk("to_addr", 64'(bus.BUS_ADDR), 64'h3000);
    REQ_ENA = 2'b10;
    e.ack = 2'b01; e.rdata = 32'h0; e.resp = RESP_DECERR;
    exp_q.push_back(e);
    ena_seen = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge ACLK);
      if (k == 8) chk("to_ack", 64'(REQ_ACK), 64'd1);
      if (k == 7) chk("to_not_early", 64'(REQ_ACK), 64'd0);
      if (k == 9) chk("to_ack_single", 64'(REQ_ACK), 64'd0);
      if (bus.BUS_ENA) ena_seen++;
    end
    chk("drain_no_ena", 64'(ena_seen), 64'd0);
    done_drive(32'h9999_9999, RESP_OKAY);
    @(negedge ACLK);
    done_clear();
    chk("drain_no_ack", 64'(REQ_ACK), 64'd0);
    chk("drain_exit_no_ena", 64'(bus.BUS_ENA), 64'd0);
    @(negedge ACLK);
    chk("post_drain_ena", 64'(bus.BUS_ENA), 64'd1);
    chk("post_drain_addr", 64'(bus.BUS_ADDR), 64'h3000_0000);
    REQ_ENA = 2'b00;
    e.ack = 2'b10; e.rdata = 32'h7777_0001; e.resp = RESP_OKAY;
    exp_q.push_back(e);
    @(negedge ACLK);
    done_drive(32'h7777_0001, RESP_OKAY);
    @(negedge ACLK);
    done_clear();
    chk("post_drain_ack", 64'(REQ_ACK), 64'd2);
    @(negedge ACLK);

    // Completion on the expiry cycle is a normal completion, and no drain follows.
    xfer(mk(2'b01, 4'h0, 32'h0000_4000, 32'h0, 4'h0, 32'h0000_4100, 32'h0, 7, 32'h5555_AAAA, RESP_SLVERR, 0));
    xfer(mk(2'b10, 4'h0, 32'h0000_4200, 32'h0, 4'h0, 32'h0000_4300, 32'h0, 1, 32'h0000_4444, RESP_OKAY, 1));

    // Stray completion while idle is ignored.
    done_drive(32'h1111_1111, RESP_OKAY);
    @(negedge ACLK);
    done_clear();
    chk("idle_done_no_ack", 64'(REQ_ACK), 64'd0);
    @(negedge ACLK);
    chk("idle_done_no_ack2", 64'(REQ_ACK), 64'd0);
    chk("idle_done_no_ena", 64'(bus.BUS_ENA), 64'd0);
    xfer(mk(2'b10, 4'h0, 32'h0000_4400, 32'h0, 4'h0, 32'h0000_4500, 32'h0, 2, 32'h0000_4545, RESP_OKAY, 1));

    // Contention with both requests held: alternating grants at latency+2 per transfer.
    REQ_ADDR  = {32'h0000_7100, 32'h0000_7000};
    REQ_WSTB  = '0;
    REQ_WDATA = '0;
    REQ_ENA   = 2'b11;
    for (int t = 0; t < 4; t++) begin
      oh = 2'b01 << order[t];
      @(negedge ACLK);
      chk("cont_ena", 64'(bus.BUS_ENA), 64'd1);
      chk("cont_addr", 64'(bus.BUS_ADDR), (order[t] == 1) ? 64'h7100 : 64'h7000);
      e.ack = oh; e.rdata = 32'h7700_0000 + 32'(t); e.resp = RESP_OKAY;
      exp_q.push_back(e);
      @(negedge ACLK);
      chk("cont_wait_ena", 64'(bus.BUS_ENA), 64'd0);
      @(negedge ACLK);
      done_drive(32'h7700_0000 + 32'(t), RESP_OKAY);
      @(negedge ACLK);
      done_clear();
      chk("cont_ack", 64'(REQ_ACK), 64'(oh));
      if (t == 3) REQ_ENA = 2'b00;
    end
    @(negedge ACLK);
    chk("cont_idle", 64'(bus.BUS_ENA), 64'd0);

    // Reset while waiting aborts the transfer without an ACK.
    REQ_ENA   = 2'b01;
    REQ_ADDR  = {32'h5000_0004, 32'h5000_0000};
    REQ_WSTB  = {4'h0, 4'hF};
    REQ_WDATA = {32'h0, 32'hCAFE_0000};
    @(negedge ACLK);
    chk("rw_issue", 64'(bus.BUS_ENA), 64'd1);
    REQ_ENA = 2'b00;
    @(negedge ACLK);
    #2 ARESETn = 1'b0;
    #1;
    chk("rw_ack", 64'(REQ_ACK), 64'd0);
    chk("rw_rdata", 64'(REQ_RDATA), 64'd0);
    chk("rw_resp", 64'(REQ_RESP), 64'd0);
    chk("rw_ena", 64'(bus.BUS_ENA), 64'd0);
    chk("rw_wstb", 64'(bus.BUS_WSTB), 64'd0);
    chk("rw_addr", 64'(bus.BUS_ADDR), 64'd0);
    chk("rw_wdata", 64'(bus.BUS_WDATA), 64'd0);
    outstanding = 1'b0;
    @(negedge ACLK);
    @(negedge ACLK);
    ARESETn = 1'b1;
    REQ_ENA = 2'b10;
    @(negedge ACLK);
    chk("rw_regrant_ena", 64'(bus.BUS_ENA), 64'd1);
    chk("rw_regrant_addr", 64'(bus.BUS_ADDR), 64'h5000_0004);
    REQ_ENA = 2'b00;
    e.ack = 2'b10; e.rdata = 32'h0BEE_F00D; e.resp = RESP_OKAY;
    exp_q.push_back(e);
    @(negedge ACLK);
    done_drive(32'h0BEE_F00D, RESP_OKAY);
    @(negedge ACLK);
    done_clear();
    chk("rw_regrant_ack", 64'(REQ_ACK), 64'd2);
    @(negedge ACLK);

    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axilm_bus_arb.md
Name: axilm_bus_arb

Overview:
- N-requester round-robin arbiter in front of the AXI-Lite master local interface (BUS_ENA/BUS_WSTB/BUS_ADDR/BUS_WDATA out, BUS_DONE/BUS_RDATA/BUS_RESP in).
- Grants one requester at a time and holds the grant until the master reports completion.
- Returns read data and response to the granted requester only.
- A watchdog ends a hung transfer with an error response, then drains the late completion.

Parameters:
- NREQ, 2, number of requesters (2..8).
- TIMEOUT, 256, cycles allowed from BUS_ENA to BUS_DONE; 0 disables the watchdog.
- CNT_W, 16, watchdog counter width; must satisfy TIMEOUT < 2**CNT_W.

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  asynchronous active-low reset
- REQ_ENA  in  NREQ  per-requester request level; held until that requester's REQ_ACK
- REQ_WSTB  in  4*NREQ  write strobes, slice i = [4i+3:4i]; all-zero = read
- REQ_ADDR  in  32*NREQ  byte address, slice i
- REQ_WDATA  in  32*NREQ  write data, slice i
- REQ_ACK  out  NREQ  one-cycle completion pulse, one-hot
- REQ_RDATA  out  32  read data, valid with REQ_ACK
- REQ_RESP  out  2  AXI response (RRESP or BRESP), valid with REQ_ACK
- BUS_ENA  out  1  one-cycle issue pulse to the master
- BUS_WSTB  out  4  strobes of the granted requester
- BUS_ADDR  out  32  address of the granted requester
- BUS_WDATA  out  32  write data of the granted requester
- BUS_DONE  in  1  one-cycle completion pulse from the master
- BUS_RDATA  in  32  master read data, valid with BUS_DONE
- BUS_RESP  in  2  master response, valid with BUS_DONE

Behaviour:
- Reset (async, ARESETn low):
  - All outputs 0; state IDLE; rr_ptr = 0; watchdog = 0.
  - Asserting reset mid-transfer aborts immediately, with no ACK.
- IDLE:
  - Choose the first asserted REQ_ENA bit, scanning from rr_ptr upward with wrap modulo NREQ.
  - On a hit: latch grant index g, register BUS_ADDR/BUS_WSTB/BUS_WDATA from slice g, pulse BUS_ENA for one cycle, go to WAIT.
  - Latency from request to BUS_ENA: 1 cycle.
  - No request: stay in IDLE; BUS_* outputs keep their last values.
- WAIT:
  - Watchdog increments every cycle.
  - BUS_DONE=1: register REQ_RDATA=BUS_RDATA, REQ_RESP=BUS_RESP, pulse REQ_ACK[g] the next cycle, set rr_ptr=(g+1) mod NREQ, go to IDLE. ACK appears 1 cycle after BUS_DONE.
  - TIMEOUT!=0 and watchdog==TIMEOUT-1 with no BUS_DONE: pulse REQ_ACK[g] with REQ_RESP=2'b11 (DECERR) and REQ_RDATA=0, advance rr_ptr, go to DRAIN.
  - BUS_DONE in the same cycle the watchdog expires: BUS_DONE wins and this is a normal completion.
- DRAIN:
  - No grants are made.
  - On BUS_DONE: discard the data, go to IDLE. No ACK is issued.
- ACK cycle:
  - The arbiter returns to IDLE in the same edge as the ACK, but it can issue the next BUS_ENA no earlier than the following edge.
  - The requester deasserts or re-arms REQ_ENA on seeing REQ_ACK.
  - Back-to-back throughput: one transfer per (bus latency + 2) cycles.
- Requester-side rules:
  - REQ_ENA[g] dropping while in WAIT has no effect; the transfer completes and ACK is still pulsed.
  - REQ_ADDR/WSTB/WDATA changing after issue has no effect, since the values are latched.
- Fairness: after serving g, g has lowest priority; a continuously requesting source waits at most NREQ-1 transfers.
- The master's BUS_DONE is ignored in IDLE (protocol violation); the arbiter does not change state.
- Read/write distinction passes through untouched via BUS_WSTB; the arbiter is direction-agnostic.

Decomposition:
- Package axilm_pkg:
  - enum arb_state_t {IDLE=0, WAIT=1, DRAIN=2}, 2-bit.
  - Response constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
- Sub-module axilm_rr_pick: combinational round-robin picker.
  - Inputs: req[NREQ], ptr.
  - Outputs: hit, idx.
  - Reusable for future write/read channel arbitration.
- Watchdog counter and FSM stay in axilm_bus_arb.

Test Plan:
- Single read, NREQ=2: REQ_ENA=01, REQ_WSTB0=0, REQ_ADDR0=0x1000; slave returns BUS_RDATA=0xDEADBEEF, BUS_RESP=0 after 3 cycles -> BUS_ENA pulses 1 cycle after request with BUS_ADDR=0x1000; REQ_ACK=01 1 cycle after BUS_DONE with REQ_RDATA=0xDEADBEEF, REQ_RESP=00.
- Contention: REQ_ENA=11 held, 4 transfers -> grant order 0,1,0,1; REQ_ACK pulses alternate 01,10,01,10; no BUS_ENA while in WAIT.
- Write pass-through: requester 1 with WSTB=0xF, ADDR=0x2004, WDATA=0x12345678 -> BUS_WSTB=0xF, BUS_ADDR=0x2004, BUS_WDATA=0x12345678; REQ_ACK=10.
- Timeout: TIMEOUT=8, BUS_DONE withheld -> REQ_ACK pulses on cycle 8 after BUS_ENA with REQ_RESP=11, REQ_RDATA=0. With a pending request, no BUS_ENA until a late BUS_DONE at cycle 20; the next grant is issued 1 cycle after that BUS_DONE.
- Boundary: BUS_DONE coincides with watchdog expiry -> normal ACK carrying the slave's RESP; no DRAIN entry.
- Reset mid-WAIT: ARESETn low 2 cycles during WAIT -> all outputs 0 immediately; after release with REQ_ENA=10, requester 1 is granted (rr_ptr=0 scan, bit 0 idle).
